// File: rtl/logic_op_pkg.sv
// Shared encodings for the logical-operation monitor: FSM states and the
// result record layout {and, or, eq, cond}.
package logic_op_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic and_r;
    logic or_r;
    logic eq_r;
    logic cond_r;
  } result_t;

endpackage

// File: rtl/logic_op_eval.sv
// Combinational evaluation of one operand pair into the four result bits.
// Shared with the stimulus-side scoreboard, so keep it free of state.
module logic_op_eval
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output result_t          res_o
);

  logic a_nz;
  logic b_nz;

  assign a_nz = |a_i;
  assign b_nz = |b_i;

  assign res_o.and_r  = a_nz && b_nz;
  assign res_o.or_r   = a_nz || b_nz;
  assign res_o.eq_r   = (a_i == b_i);
  // Only bits [3:2] and the full-width zero test take part in cond.
  assign res_o.cond_r = ((a_i[3] == b_i[3]) && (a_i[2] != b_i[2])) || !a_nz;

endmodule

// File: rtl/logic_op_monitor.sv
// Consumes (a, b) operand pairs over valid/ready, emits one registered
// result record per pair, counts cond hits and stops after NUM_SAMPLES.
module logic_op_monitor
  import logic_op_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_SAMPLES = 9,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and,
  output logic             out_or,
  output logic             out_eq,
  output logic             out_cond,
  output logic [CNT_W-1:0] out_index,
  output logic [CNT_W-1:0] cond_count,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  result_t            res_q, res_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   out_index_q, out_index_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]   cond_count_q, cond_count_d;
  result_t            eval_res;
  logic               accept;
  logic [CNT_W:0]     acc_plus;

  logic_op_eval #(.WIDTH(WIDTH)) u_eval (
    .a_i   (in_a),
    .b_i   (in_b),
    .res_o (eval_res)
  );

  // Single-entry output register with pass-through: a pair may be taken in
  // the same cycle the held record is consumed.
  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_plus = {1'b0, acc_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    res_d        = res_q;
    out_valid_d  = out_valid_q;
    out_index_d  = out_index_q;
    acc_cnt_d    = acc_cnt_q;
    cond_count_d = cond_count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          acc_cnt_d    = '0;
          cond_count_d = '0;
          out_valid_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          res_d       = eval_res;
          out_index_d = acc_cnt_q;
          out_valid_d = 1'b1;
          acc_cnt_d   = acc_plus[CNT_W-1:0];
          if (eval_res.cond_r && (cond_count_q != {CNT_W{1'b1}})) begin
            cond_count_d = cond_count_q + 1'b1;
          end
          // Wider compare so NUM_SAMPLES == 2**CNT_W still terminates.
          if (acc_plus == (CNT_W+1)'(NUM_SAMPLES)) begin
            state_d = ST_DRAIN;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      res_q        <= '0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      acc_cnt_q    <= '0;
      cond_count_q <= '0;
    end else begin
      state_q      <= state_d;
      res_q        <= res_d;
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      acc_cnt_q    <= acc_cnt_d;
      cond_count_q <= cond_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_and    = res_q.and_r;
  assign out_or     = res_q.or_r;
  assign out_eq     = res_q.eq_r;
  assign out_cond   = res_q.cond_r;
  assign out_index  = out_index_q;
  assign cond_count = cond_count_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_logic_op_monitor.sv
// Bench for logic_op_monitor: directed scenarios plus randomized runs checked
// against a behavioural model of the pair stream and record register.
module tb_logic_op_monitor;

  localparam int WIDTH       = 8;
  localparam int NUM_SAMPLES = 9;
  localparam int CNT_W       = 16;

  logic             clk = 1'b0;
  logic             rst_n, start, in_valid, in_ready, out_valid, out_ready;
  logic             out_and, out_or, out_eq, out_cond, busy, done;
  logic [WIDTH-1:0] in_a, in_b;
  logic [CNT_W-1:0] out_index, cond_count;

  always #5 clk = ~clk;

  logic_op_monitor #(.WIDTH(WIDTH), .NUM_SAMPLES(NUM_SAMPLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_and(out_and), .out_or(out_or), .out_eq(out_eq), .out_cond(out_cond),
    .out_index(out_index), .cond_count(cond_count), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0 idle, 1 taking pairs, 2 waiting for last record, 3 finished.
  int       m_phase = 0;
  int       m_acc   = 0;
  int       m_hits  = 0;
  bit       m_pend  = 0;
  bit [3:0] m_rec   = 0;
  int       m_idx   = 0;

  function automatic bit [3:0] ref_eval(int a, int b);
    bit an, orr, eq, c;
    an  = (a != 0) && (b != 0);
    orr = (a != 0) || (b != 0);
    eq  = (a == b);
    c   = ((((a >> 3) & 1) == ((b >> 3) & 1)) && (((a >> 2) & 1) != ((b >> 2) & 1))) || (a == 0);
    return {an, orr, eq, c};
  endfunction

  function automatic bit m_rdy();
    return (m_phase == 1) && (!m_pend || out_ready);
  endfunction

  task automatic set_in(bit st, bit v, int a, int b, bit r);
    start     = st;
    in_valid  = v;
    in_a      = a[WIDTH-1:0];
    in_b      = b[WIDTH-1:0];
    out_ready = r;
    #1;
  endtask

  task automatic clk_step();
    bit acc, cons;
    if (!rst_n) begin
      m_phase = 0; m_acc = 0; m_hits = 0; m_pend = 0; m_rec = 0; m_idx = 0;
    end else begin
      acc  = in_valid && m_rdy();
      cons = m_pend && out_ready;
      if ((m_phase == 0 || m_phase == 3) && start) begin
        m_phase = 1; m_acc = 0; m_hits = 0;
      end else if (m_phase == 1 && acc) begin
        m_rec  = ref_eval(int'(in_a), int'(in_b));
        m_idx  = m_acc % (1 << CNT_W);
        m_acc += 1;
        if (m_rec[0] && m_hits < (1 << CNT_W) - 1) m_hits += 1;
        m_pend = 1;
        if (m_acc == NUM_SAMPLES) m_phase = 2;
      end else if (cons) begin
        m_pend = 0;
        if (m_phase == 2) m_phase = 3;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run();
    for (int c = 0; c < 40 && m_phase != 3; c++) begin
      set_in(0, 1, $urandom, $urandom, 1);
      clk_step();
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL finish_done: got %b want 1", done); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1, 1, $urandom, $urandom, 1);
    repeat (3) begin
      clk_step();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_vec++; if (cond_count !== '0) begin n_err++; $display("FAIL rst_cond_count: got %0d want 0", cond_count); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    end
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0);
    clk_step();
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_idle: got busy=%b done=%b want 0 0", busy, done); end
    n_vec++; if (out_index !== '0) begin n_err++; $display("FAIL rst_out_index: got %0d want 0", out_index); end
  endtask

  task automatic test_single();
    set_in(1, 0, 0, 0, 1);
    clk_step();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    set_in(0, 1, 8'h00, 8'h00, 1);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", in_ready); end
    clk_step();
    set_in(0, 0, 0, 0, 0);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_vec++; if ({out_and, out_or, out_eq, out_cond} !== 4'b0011) begin n_err++; $display("FAIL single_rec: got %b want 0011", {out_and, out_or, out_eq, out_cond}); end
    n_vec++; if (out_index !== 16'd0 || cond_count !== 16'd1) begin n_err++; $display("FAIL single_cnt: got idx=%0d cnt=%0d want 0 1", out_index, cond_count); end
  endtask

  task automatic test_mixed();
    set_in(0, 1, 8'h08, 8'h0C, 1);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mixed_passthru: got %b want 1", in_ready); end
    clk_step();
    n_vec++; if ({out_and, out_or, out_eq, out_cond} !== 4'b1101) begin n_err++; $display("FAIL mixed_rec1: got %b want 1101", {out_and, out_or, out_eq, out_cond}); end
    n_vec++; if (out_index !== 16'd1 || cond_count !== 16'd2) begin n_err++; $display("FAIL mixed_cnt1: got idx=%0d cnt=%0d want 1 2", out_index, cond_count); end
    set_in(0, 1, 8'h04, 8'h04, 1);
    clk_step();
    n_vec++; if ({out_and, out_or, out_eq, out_cond} !== 4'b1110) begin n_err++; $display("FAIL mixed_rec2: got %b want 1110", {out_and, out_or, out_eq, out_cond}); end
    n_vec++; if (out_index !== 16'd2 || cond_count !== 16'd2) begin n_err++; $display("FAIL mixed_cnt2: got idx=%0d cnt=%0d want 2 2", out_index, cond_count); end
    finish_run();
  endtask

  task automatic test_full_throughput();
    int nrec = 0, last = -1, done_cyc = -1;
    set_in(1, 0, 0, 0, 1);
    clk_step();
    for (int c = 0; c < 30 && done_cyc < 0; c++) begin
      set_in(0, 1, $urandom, $urandom, 1);
      n_vec++; if (in_ready !== m_rdy()) begin n_err++; $display("FAIL ft_ready c=%0d: got %b want %b", c, in_ready, m_rdy()); end
      clk_step();
      if (out_valid === 1'b1) begin
        n_vec++; if (out_index !== CNT_W'(nrec)) begin n_err++; $display("FAIL ft_index: got %0d want %0d", out_index, nrec); end
        n_vec++; if ({out_and, out_or, out_eq, out_cond} !== m_rec) begin n_err++; $display("FAIL ft_rec: got %b want %b", {out_and, out_or, out_eq, out_cond}, m_rec); end
        nrec++;
        last = c;
      end
      if (done === 1'b1) done_cyc = c;
    end
    n_vec++; if (nrec != NUM_SAMPLES || last != NUM_SAMPLES - 1) begin n_err++; $display("FAIL ft_records: got %0d ending c=%0d want %0d ending c=%0d", nrec, last, NUM_SAMPLES, NUM_SAMPLES - 1); end
    n_vec++; if (done_cyc != last + 1) begin n_err++; $display("FAIL ft_done_timing: got c=%0d want c=%0d", done_cyc, last + 1); end
  endtask

  task automatic test_backpressure();
    bit [3:0] hold_rec;
    int       hold_idx, nxt;
    set_in(1, 0, 0, 0, 1);
    clk_step();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, $urandom, $urandom, 1);
      clk_step();
    end
    hold_rec = m_rec;
    hold_idx = m_idx;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, $urandom, $urandom, 0);
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready i=%0d: got %b want 0", i, in_ready); end
      clk_step();
      n_vec++; if (out_valid !== 1'b1 || out_index !== CNT_W'(hold_idx) || {out_and, out_or, out_eq, out_cond} !== hold_rec) begin
        n_err++; $display("FAIL bp_hold i=%0d: got v=%b idx=%0d rec=%b want 1 %0d %b", i, out_valid, out_index, {out_and, out_or, out_eq, out_cond}, hold_idx, hold_rec);
      end
    end
    nxt = hold_idx + 1;
    for (int c = 0; c < 30 && m_phase != 3; c++) begin
      set_in(0, 1, $urandom, $urandom, 1);
      clk_step();
      if (out_valid === 1'b1) begin
        n_vec++; if (out_index !== CNT_W'(nxt)) begin n_err++; $display("FAIL bp_index: got %0d want %0d", out_index, nxt); end
        nxt++;
      end
    end
    n_vec++; if (nxt != NUM_SAMPLES || done !== 1'b1) begin n_err++; $display("FAIL bp_complete: got next=%0d done=%b want %0d 1", nxt, done, NUM_SAMPLES); end
  endtask

  task automatic test_restart();
    set_in(1, 0, 0, 0, 1);
    clk_step();
    for (int c = 0; c < 30 && m_phase != 2; c++) begin
      set_in(0, 1, $urandom, $urandom, 1);
      clk_step();
    end
    n_vec++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL rs_drain: got busy=%b v=%b want 1 1", busy, out_valid); end
    rst_n = 1'b0;
    set_in(1, 0, 0, 0, 0);
    clk_step();
    rst_n = 1'b1;
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL rs_clear: got v=%b busy=%b done=%b rdy=%b want 0 0 0 0", out_valid, busy, done, in_ready);
    end
    n_vec++; if (cond_count !== '0 || out_index !== '0) begin n_err++; $display("FAIL rs_counts: got cnt=%0d idx=%0d want 0 0", cond_count, out_index); end
    set_in(1, 0, 0, 0, 1);
    clk_step();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, $urandom, 1);
      clk_step();
    end
    n_vec++; if (out_index !== 16'd2 || cond_count !== 16'd3) begin n_err++; $display("FAIL rs_restart: got idx=%0d cnt=%0d want 2 3", out_index, cond_count); end
    set_in(1, 1, 0, 8'h55, 1);
    clk_step();
    n_vec++; if (out_index !== 16'd3 || cond_count !== 16'd4) begin n_err++; $display("FAIL rs_start_ignored: got idx=%0d cnt=%0d want 3 4", out_index, cond_count); end
    finish_run();
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      set_in(1, 0, 0, 0, 1);
      clk_step();
      for (int c = 0; c < 400 && m_phase != 3; c++) begin
        int a, b;
        a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
        b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 255));
        set_in($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3) != 0);
        n_vec++; if (in_ready !== m_rdy()) begin n_err++; $display("FAIL rnd_ready: got %b want %b", in_ready, m_rdy()); end
        clk_step();
        n_vec++; if (out_valid !== m_pend || cond_count !== CNT_W'(m_hits)) begin
          n_err++; $display("FAIL rnd_state: got v=%b cnt=%0d want %b %0d", out_valid, cond_count, m_pend, m_hits);
        end
        n_vec++; if (busy !== (m_phase == 1 || m_phase == 2) || done !== (m_phase == 3)) begin
          n_err++; $display("FAIL rnd_flags: got busy=%b done=%b want phase %0d", busy, done, m_phase);
        end
        if (m_pend) begin
          n_vec++; if ({out_and, out_or, out_eq, out_cond} !== m_rec || out_index !== CNT_W'(m_idx)) begin
            n_err++; $display("FAIL rnd_rec: got %b idx=%0d want %b idx=%0d", {out_and, out_or, out_eq, out_cond}, out_index, m_rec, m_idx);
          end
        end
      end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL rnd_timeout run %0d: got done=%b want 1", r, done); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_mixed();
    test_full_throughput();
    test_backpressure();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
